shift_exec_stage: RTL and testbench

//  Execute-stage wrapper for the 16-bit shifter: accepts shift requests from decode over valid/ready,

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_unit.sv | 29 ++
 rtl/shift_exec_stage.sv | 77 +++++++
 tb/tb_shift_exec_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants and request/response types for the shift execute stage.
package shift_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;
    localparam int RD_W   = 3;

    localparam logic LORR_LEFT  = 1'b0;
    localparam logic LORR_RIGHT = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amount;
        logic              lorr;
        logic [RD_W-1:0]   rd;
    } shift_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
        logic              zero;
        logic              carry;
    } shift_rsp_t;

endpackage

// File: rtl/shift_unit.sv
// Combinational logical shifter (zero fill). Flags are produced only when
// SHIFT_FLAGS_EN is defined; otherwise they are driven to 0.
module shift_unit
    import shift_pkg::*;
(
    input  shift_req_t req,
    output shift_rsp_t rsp
);

`ifdef SHIFT_FLAGS_EN
    logic [DATA_W:0] left_ext;
    logic [DATA_W:0] right_ext;
`endif

    always_comb begin
        rsp      = '0;
        rsp.data = (req.lorr == LORR_RIGHT) ? (req.data >> req.amount)
                                            : (req.data << req.amount);
        rsp.rd   = req.rd;
`ifdef SHIFT_FLAGS_EN
        // The extra guard bit catches the last bit shifted out; amount 0 leaves it 0.
        left_ext  = {1'b0, req.data} << req.amount;
        right_ext = {req.data, 1'b0} >> req.amount;
        rsp.zero  = (rsp.data == '0);
        rsp.carry = (req.lorr == LORR_RIGHT) ? right_ext[0] : left_ext[DATA_W];
`endif
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Execute-stage wrapper around shift_unit: registered result with a 2-entry
// output skid buffer and flush. Optional flags via SHIFT_FLAGS_EN.
module shift_exec_stage
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amount,
    input  logic              in_lorr,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_zero,
    output logic              out_carry
);

    shift_req_t req;
    shift_rsp_t shifted;
    shift_rsp_t main_rsp;
    shift_rsp_t skid_rsp;
    logic       main_valid;
    logic       skid_valid;
    logic       accept;
    logic       main_free;

    assign req = '{data: in_data, amount: in_amount, lorr: in_lorr, rd: in_rd};

    shift_unit u_shift_unit (
        .req (req),
        .rsp (shifted)
    );

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign main_free = ~main_valid | out_ready;

    // Skid is only ever full while main is full, so skid -> main and a new
    // accept into main are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_rsp   <= '0;
            skid_rsp   <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_rsp   <= skid_rsp;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_rsp   <= shifted;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_rsp   <= shifted;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_rsp.data;
    assign out_rd    = main_rsp.rd;
    assign out_zero  = main_rsp.zero;
    assign out_carry = main_rsp.carry;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage (flag checks follow SHIFT_FLAGS_EN).
module tb_shift_exec_stage;
    import shift_pkg::*;

`ifdef SHIFT_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [AMT_W-1:0]  in_amount;
    logic              in_lorr;
    logic [RD_W-1:0]   in_rd;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_zero;
    logic              out_carry;

    int tests_run = 0;
    int tests_failed = 0;

    logic [RD_W+DATA_W-1:0] rx_q[$];

    shift_exec_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_lorr   (in_lorr),
        .in_rd     (in_rd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_zero  (out_zero),
        .out_carry (out_carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && out_valid && out_ready)
            rx_q.push_back({out_rd, out_data});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] a,
                         input logic l, input logic [2:0] r);
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = a;
        in_lorr   = l;
        in_rd     = r;
    endtask

    // Present one op until accepted (bounded), then drop in_valid.
    task automatic send(input logic [15:0] d, input logic [3:0] a,
                        input logic l, input logic [2:0] r, input bit rand_ready);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        drive(d, a, l, r);
        while (!acc && n < 50) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            acc = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: op d=%h never accepted", d);
        end
    endtask

    task automatic wait_rx(input int count, input string name);
        int n;
        n = 0;
        while (rx_q.size() < count && n < 100) begin
            step();
            n++;
        end
        tests_run++;
        if (rx_q.size() != count) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d results, expected %0d", name, rx_q.size(), count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({out_valid, in_ready, out_data, out_rd, out_zero, out_carry} !== {1'b0, 1'b1, 16'h0, 3'h0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b ready=%b data=%h rd=%h z=%b c=%b, expected 0 1 0000 0 0 0",
                     out_valid, in_ready, out_data, out_rd, out_zero, out_carry);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        rx_q.delete();
        out_ready = 1'b1;
        drive(16'h0004, 4'd2, LORR_LEFT, 3'd3);
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 16'h0010 || out_rd !== 3'd3) begin
            tests_failed++;
            $display("FAIL basic_left: valid=%b data=%h rd=%0d, expected 1 0010 3", out_valid, out_data, out_rd);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0 || rx_q.size() != 1) begin
            tests_failed++;
            $display("FAIL basic_drain: valid=%b rx=%0d, expected 0 1", out_valid, rx_q.size());
        end
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        drive(16'h0005, 4'd5, LORR_RIGHT, 3'd1);
        step();
        drive(16'h8001, 4'd1, LORR_LEFT, 3'd2);
        tests_run++;
        if (out_data !== 16'h0000 || out_zero !== FLAGS_ON || out_carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL flags_right: data=%h z=%b c=%b, expected 0000 %b 0", out_data, out_zero, out_carry, FLAGS_ON);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_data !== 16'h0002 || out_rd !== 3'd2 || out_zero !== 1'b0 || out_carry !== FLAGS_ON) begin
            tests_failed++;
            $display("FAIL flags_left: data=%h rd=%0d z=%b c=%b, expected 0002 2 0 %b",
                     out_data, out_rd, out_zero, out_carry, FLAGS_ON);
        end
        drive(16'h00F0, 4'd0, LORR_RIGHT, 3'd7);
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_data !== 16'h00F0 || out_zero !== 1'b0 || out_carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL flags_amt0: data=%h z=%b c=%b, expected 00F0 0 0", out_data, out_zero, out_carry);
        end
        step();
    endtask

    task automatic test_back_pressure();
        rx_q.delete();
        out_ready = 1'b0;
        drive(16'h0001, 4'd1, LORR_LEFT, 3'd1);
        step();
        drive(16'h00F0, 4'd4, LORR_RIGHT, 3'd2);
        step();
        drive(16'h1234, 4'd4, LORR_LEFT, 3'd5);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_ready_drop: in_ready=%b, expected 0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 16'h0002 || out_rd !== 3'd1 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_stall_hold: valid=%b data=%h rd=%0d ready=%b, expected 1 0002 1 0",
                         out_valid, out_data, out_rd, in_ready);
            end
        end
        out_ready = 1'b1;
        send(16'h1234, 4'd4, LORR_LEFT, 3'd5, 1'b0);
        wait_rx(3, "bp");
        tests_run++;
        if (rx_q.size() != 3 || rx_q[0] !== {3'd1, 16'h0002} || rx_q[1] !== {3'd2, 16'h000F}
            || rx_q[2] !== {3'd5, 16'h2340}) begin
            tests_failed++;
            $display("FAIL bp_order: got %p, expected 1:0002 2:000f 5:2340", rx_q);
        end
    endtask

    task automatic test_flush();
        rx_q.delete();
        out_ready = 1'b0;
        send(16'h0003, 4'd1, LORR_LEFT, 3'd1, 1'b0);
        send(16'h0003, 4'd2, LORR_LEFT, 3'd2, 1'b0);
        drive(16'h0003, 4'd3, LORR_LEFT, 3'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_held: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
        end
        // Flush must also beat an accept and an output transfer in the same cycle.
        out_ready = 1'b1;
        drive(16'h0007, 4'd1, LORR_LEFT, 3'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_accept: valid=%b, expected 0", out_valid);
        end
        step();
        step();
        tests_run++;
        if (rx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL flush_none_delivered: got %0d results, expected 0", rx_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        rx_q.delete();
        out_ready = 1'b0;
        send(16'h0010, 4'd1, LORR_LEFT, 3'd1, 1'b0);
        send(16'h0010, 4'd2, LORR_LEFT, 3'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        step();
        tests_run++;
        if (out_valid !== 1'b0 || rx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_no_stale: valid=%b rx=%0d, expected 0 0", out_valid, rx_q.size());
        end
    endtask

    task automatic test_throughput();
        int n;
        rx_q.delete();
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            drive(16'(i), 4'd1, LORR_LEFT, 3'(i));
            if (in_ready === 1'b1) n++;
            step();
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if (n != 8 || rx_q.size() != 8) begin
            tests_failed++;
            $display("FAIL throughput: ready_cycles=%0d rx=%0d after 9 cycles, expected 8 8", n, rx_q.size());
        end
    endtask

    task automatic test_streaming();
        logic [RD_W+DATA_W-1:0] exp_q[$];
        int bad;
        rx_q.delete();
        for (int i = 0; i < 16; i++) begin
            logic l;
            logic [15:0] e;
            l = 1'(i % 2);
            e = l ? (16'hFFFF >> i) : (16'hFFFF << i);
            exp_q.push_back({3'(i), e});
            send(16'hFFFF, 4'(i), l, 3'(i), 1'b1);
        end
        out_ready = 1'b1;
        wait_rx(16, "stream");
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL stream_scoreboard: %0d mismatching entries, got %p expected %p", bad, rx_q, exp_q);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amount = '0;
        in_lorr   = 1'b0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_flags();
        test_back_pressure();
        test_flush();
        test_reset_midstream();
        test_throughput();
        test_streaming();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
